// File: rtl/cond_holds_unit_pkg.sv
// rtl/cond_holds_unit_pkg.sv - shared condition-code and flag types (package data_structures)
package data_structures;

   typedef enum logic [3:0] {
      C_EQ = 4'b0000, C_NE = 4'b0001, C_CS = 4'b0010, C_CC = 4'b0011,
      C_MI = 4'b0100, C_PL = 4'b0101, C_VS = 4'b0110, C_VC = 4'b0111,
      C_HI = 4'b1000, C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011,
      C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110, C_NV = 4'b1111
   } cond_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

endpackage

// File: rtl/cond_holds_unit_base_eval.sv
// rtl/cond_holds_unit_base_eval.sv - cond_base_eval: un-inverted condition from cond[3:1] and NZCV
module cond_base_eval
   import data_structures::*;
(
   input  logic [2:0] sel_i,
   input  nzcv_t      flags_i,
   output logic       base_o
);

   always_comb begin
      base_o = 1'b1;
      case (sel_i)
         3'd0: base_o = flags_i.z;
         3'd1: base_o = flags_i.c;
         3'd2: base_o = flags_i.n;
         3'd3: base_o = flags_i.v;
         3'd4: base_o = flags_i.c & ~flags_i.z;
         3'd5: base_o = (flags_i.n == flags_i.v);
         3'd6: base_o = ~flags_i.z & (flags_i.n == flags_i.v);
         default: base_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_holds_unit.sv
// rtl/cond_holds_unit.sv - AArch64 condition-holds evaluator; COND_HOLDS_OUT_REG_EN adds a 1-cycle output register
module cond_holds_unit
   import data_structures::*;
(
   input  logic       in_clk,
   input  logic       in_rst,
   input  logic       in_valid,
   input  logic [3:0] in_cond,
   input  logic [3:0] in_nzcv,
   output logic       out_valid,
   output logic       out_cond_holds
);

   logic base;
   logic valid_d;
   logic holds_d;

   cond_base_eval u_base_eval (
      .sel_i   (in_cond[3:1]),
      .flags_i (nzcv_t'(in_nzcv)),
      .base_o  (base)
   );

   // NV shares AL's encoding slot for "always", so its low bit must not invert
   always_comb begin
      valid_d = in_valid;
      holds_d = 1'b0;
      if (in_valid) begin
         holds_d = (in_cond[0] && (in_cond != C_NV)) ? ~base : base;
      end
   end

`ifdef COND_HOLDS_OUT_REG_EN
   logic valid_q;
   logic holds_q;

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         valid_q <= 1'b0;
         holds_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         holds_q <= holds_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_cond_holds = holds_q;
`else
   logic unused_ok;
   assign unused_ok      = &{1'b0, in_clk, in_rst};
   assign out_valid      = valid_d;
   assign out_cond_holds = holds_d;
`endif

endmodule

// File: tb/tb_cond_holds_unit.sv
// tb/tb_cond_holds_unit.sv - self-checking bench for cond_holds_unit (handles COND_HOLDS_OUT_REG_EN builds)
module tb_cond_holds_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [3:0] cond;
   logic [3:0] nzcv;
   logic       out_valid;
   logic       out_cond_holds;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cond_holds_unit dut (
      .in_clk         (clk),
      .in_rst         (rst),
      .in_valid       (valid),
      .in_cond        (cond),
      .in_nzcv        (nzcv),
      .out_valid      (out_valid),
      .out_cond_holds (out_cond_holds)
   );

   // Reference: the architectural truth table, one row per full condition code
   function automatic logic ref_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic r, input logic v, input logic [3:0] c,
                       input logic [3:0] f);
      logic exp_v, exp_h;
      @(posedge clk);
      #1;
      rst = r; valid = v; cond = c; nzcv = f;
`ifdef COND_HOLDS_OUT_REG_EN
      exp_v = r ? 1'b0 : v;
      exp_h = (r || !v) ? 1'b0 : ref_holds(c, f);
      @(posedge clk);
      #1;
`else
      exp_v = v;
      exp_h = v ? ref_holds(c, f) : 1'b0;
      #1;
`endif
      check({tag, ".valid"}, out_valid, exp_v);
      check({tag, ".holds"}, out_cond_holds, exp_h);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; cond = 4'd0; nzcv = 4'd0;
      step("reset", 1'b1, 1'b0, 4'b0000, 4'b0100);

      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            step("exhaustive", 1'b0, 1'b1, 4'(c), 4'(f));
         end
      end

      step("gt_nv_equal", 1'b0, 1'b1, 4'b1100, 4'b1001);
      step("gt_z_set",    1'b0, 1'b1, 4'b1100, 4'b1101);
      step("nv_0000",     1'b0, 1'b1, 4'b1111, 4'b0000);
      step("nv_1111",     1'b0, 1'b1, 4'b1111, 4'b1111);
      step("al_0000",     1'b0, 1'b1, 4'b1110, 4'b0000);
      step("al_1111",     1'b0, 1'b1, 4'b1110, 4'b1111);
      step("invalid_eq",  1'b0, 1'b0, 4'b0000, 4'b0100);

      // Back-to-back: result, then reset dropping it, then recovery
      step("lt_pre_rst",  1'b0, 1'b1, 4'b1011, 4'b1000);
      step("rst_mid",     1'b1, 1'b1, 4'b1011, 4'b1000);
      step("lt_post_rst", 1'b0, 1'b1, 4'b1011, 4'b1000);

      for (int i = 0; i < 200; i++) begin
         step("random", 1'b0, 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
